// File: rtl/conv_seq.sv
`default_nettype none
// ============================================================================
// Module      : conv_seq
// Description : Frame sequencer for the 5x5 / 4-bit convolution datapath.
//               Collects 25 serial pixels into a packed 100-bit image bus,
//               holds the bus stable for CONV_LAT cycles, captures the 81-bit
//               result and streams the nine 9-bit results out with a
//               valid/ready handshake and a last flag.
//               Optional feature macro: CONV_SEQ_OVERLAP_EN (load the next
//               frame while the current results are being drained).
// Revision    : 1.0 - initial release
// ============================================================================
module conv_seq #(
    parameter int CONV_LAT = 2            // datapath latency, legal 1..15
) (
    input  logic         clk,
    input  logic         rst,
    // pixel stream in
    input  logic         pix_valid,
    output logic         pix_ready,
    input  logic [3:0]   pix_data,
    // convolution datapath
    output logic [99:0]  conv_in,
    input  logic [80:0]  conv_out,
    // result stream out
    output logic         res_valid,
    input  logic         res_ready,
    output logic [8:0]   res_data,
    output logic         res_last,
    output logic         busy
);

    localparam logic [4:0] C_NPIX     = 5'd25;
    localparam logic [3:0] C_LAST_RES = 4'd8;
    localparam logic [3:0] C_LAT      = 4'(CONV_LAT);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t        state_q;
    logic [4:0]    pcnt_q;
    logic [4:0]    pcnt_d;
    logic [3:0]    wcnt_q;
    logic [3:0]    rcnt_q;
    logic [99:0]   img_q;
    logic [99:0]   img_d;
    logic [80:0]   result_q;

    logic          w_in_load;
    logic          w_in_wait;
    logic          w_in_drain;
    logic          w_pix_hs;
    logic          w_res_hs;

    // Output decode: everything below depends on registered state only.
    always_comb begin
        w_in_load  = (state_q == ST_LOAD);
        w_in_wait  = (state_q == ST_WAIT);
        w_in_drain = (state_q == ST_DRAIN);
`ifdef CONV_SEQ_OVERLAP_EN
        // Results are already captured in DRAIN, so the image bus is free to
        // take the next frame until it is full.
        pix_ready  = w_in_load | (w_in_drain & (pcnt_q < C_NPIX));
`else
        pix_ready  = w_in_load;
`endif
        res_valid  = w_in_drain;
        res_last   = w_in_drain & (rcnt_q == C_LAST_RES);
        busy       = w_in_wait | w_in_drain;
        conv_in    = img_q;
    end

    // Result selection: rcnt picks one 9-bit lane of the captured result.
    always_comb begin
        res_data = '0;
        for (int j = 0; j < 9; j++) begin
            if (rcnt_q == 4'(j)) begin
                res_data = result_q[9*j +: 9];
            end
        end
    end

    // Handshakes and pixel slot write: slots not written keep old contents.
    always_comb begin
        w_pix_hs = pix_valid & pix_ready;
        w_res_hs = res_valid & res_ready;
        pcnt_d   = w_pix_hs ? (pcnt_q + 5'd1) : pcnt_q;
        img_d    = img_q;
        for (int k = 0; k < 25; k++) begin
            if (w_pix_hs && (pcnt_q == 5'(k))) begin
                img_d[4*k +: 4] = pix_data;
            end
        end
    end

    // Sequencer FSM with its counters, image bus and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_LOAD;
            pcnt_q   <= '0;
            wcnt_q   <= '0;
            rcnt_q   <= '0;
            img_q    <= '0;
            result_q <= '0;
        end else begin
            img_q  <= img_d;
            pcnt_q <= pcnt_d;
            case (state_q)
                ST_LOAD: begin
                    if (pcnt_d == C_NPIX) begin
                        state_q <= ST_WAIT;
                        wcnt_q  <= C_LAT;
                    end
                end
                ST_WAIT: begin
                    // The image is now owned by the result register, so the
                    // pixel counter can restart for the next frame.
                    if (wcnt_q <= 4'd1) begin
                        result_q <= conv_out;
                        rcnt_q   <= '0;
                        pcnt_q   <= '0;
                        state_q  <= ST_DRAIN;
                    end else begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end
                end
                ST_DRAIN: begin
                    if (w_res_hs) begin
                        if (rcnt_q == C_LAST_RES) begin
`ifdef CONV_SEQ_OVERLAP_EN
                            // A frame completed during the drain (including
                            // this very cycle) goes straight to WAIT.
                            if (pcnt_d == C_NPIX) begin
                                state_q <= ST_WAIT;
                                wcnt_q  <= C_LAT;
                            end else begin
                                state_q <= ST_LOAD;
                            end
`else
                            state_q <= ST_LOAD;
                            pcnt_q  <= '0;
`endif
                        end else begin
                            rcnt_q <= rcnt_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_seq
// Description : Directed self-checking bench for conv_seq (CONV_LAT = 2).
//               The datapath model returns result j = 100+j only once the
//               image bus has been stable long enough, otherwise all ones.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_seq;

    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         pix_valid;
    logic         pix_ready;
    logic [3:0]   pix_data;
    logic [99:0]  conv_in;
    logic [80:0]  conv_out;
    logic         res_valid;
    logic         res_ready;
    logic [8:0]   res_data;
    logic         res_last;
    logic         busy;

    int n_chk  = 0;
    int n_pass = 0;

    logic [80:0] res_vec;
    logic [99:0] img1, img2, img3;
    logic [3:0]  f1 [25];
    int unsigned age = 1000;

    always #5 clk = ~clk;

    conv_seq #(.CONV_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .conv_in   (conv_in),
        .conv_out  (conv_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_last  (res_last),
        .busy      (busy)
    );

    // Datapath model: age counts cycles since the last pixel write.
    always @(posedge clk) begin
        if (pix_valid && pix_ready) age <= 0;
        else if (age < 1000)        age <= age + 1;
    end
    assign conv_out = (age + 1 >= LAT) ? res_vec : {81{1'b1}};

    task automatic check(input string tag, input logic [99:0] got, input logic [99:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams one 25-pixel image; toggle drives valid only on even cycles.
    task automatic send_frame(input logic [99:0] img, input bit toggle);
        int k   = 0;
        int cyc = 0;
        bit hs;
        while (k < 25 && cyc < 200) begin
            pix_data  = img[4*k +: 4];
            pix_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            hs = pix_valid && pix_ready;
            tick();
            if (hs) k++;
            cyc++;
        end
        pix_valid = 1'b0;
        check("frame_handshakes", k, 25);
        check("frame_cycles", cyc, toggle ? 49 : 25);
    endtask

    // Called in the cycle after the 25th handshake; first result is 3 after it.
    task automatic wait_res();
        int n = 1;
        while (!res_valid && n < 30) begin
            tick();
            n++;
        end
        check("first_res_latency", n, 3);
    endtask

    // Drains nine results; optional stall of stall_n cycles at index stall_j.
    task automatic drain(input int stall_j, input int stall_n, input bit busy_after);
        res_ready = 1'b1;
        for (int j = 0; j < 9; j++) begin
            if (j == stall_j) begin
                res_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    check("stall_valid", res_valid, 1);
                    check("stall_data", res_data, 100 + stall_j);
                    tick();
                end
                res_ready = 1'b1;
            end
`ifndef CONV_SEQ_OVERLAP_EN
            if (j == 0) check("drain_pix_ready", pix_ready, 0);
`endif
            check("res_valid", res_valid, 1);
            check("res_data", res_data, 100 + j);
            check("res_last", res_last, (j == 8));
            tick();
        end
        res_ready = 1'b0;
        check("after_drain_valid", res_valid, 0);
        check("after_drain_busy", busy, busy_after);
    endtask

    task automatic check_reset_outputs();
        check("rst_pix_ready", pix_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_last", res_last, 0);
        check("rst_res_data", res_data, 0);
        check("rst_busy", busy, 0);
        check("rst_conv_in", conv_in, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        f1 = '{4'd5, 4'd3, 4'd2, 4'd1, 4'd4, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3,
               4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd1, 4'd0, 4'd1, 4'd2,
               4'd3, 4'd1, 4'd0, 4'd4, 4'd1};
        for (int j = 0; j < 9; j++) res_vec[9*j +: 9] = 9'(100 + j);
        for (int k = 0; k < 25; k++) begin
            img1[4*k +: 4] = f1[k];
            img2[4*k +: 4] = 4'((k * 7 + 3) % 16);
            img3[4*k +: 4] = 4'(15 - k);
        end

        rst = 1'b1; pix_valid = 1'b0; pix_data = '0; res_ready = 1'b0;
        tick(); tick();
        check_reset_outputs();
        rst = 1'b0;

        // Frame 1, continuous pixels, consumer always ready.
        send_frame(img1, 1'b0);
        check("wait_busy", busy, 1);
        check("wait_pix_ready", pix_ready, 0);
        check("conv_in_frame1", conv_in, img1);
        check("conv_in_p0", conv_in[3:0], 5);
        check("conv_in_p24", conv_in[99:96], 1);
        wait_res();
        drain(-1, 0, 1'b0);
        check("load_pix_ready", pix_ready, 1);

        // Frame 1 again with a 4-cycle consumer stall at result 3.
        send_frame(img1, 1'b0);
        wait_res();
        drain(3, 4, 1'b0);

        // Toggled pix_valid: 25 handshakes in 49 cycles, order preserved.
        send_frame(img2, 1'b1);
        check("conv_in_toggle", conv_in, img2);
        wait_res();
        drain(-1, 0, 1'b0);

        // Reset after 12 pixels discards the partial frame.
        for (int k = 0; k < 12; k++) begin
            pix_valid = 1'b1;
            pix_data  = img3[4*k +: 4];
            tick();
        end
        pix_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs();
        send_frame(img1, 1'b0);
        check("conv_in_after_rst", conv_in, img1);
        wait_res();
        drain(-1, 0, 1'b0);

        // Reset during DRAIN at result 5: no more results afterwards.
        send_frame(img2, 1'b0);
        wait_res();
        res_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            check("pre_rst_data", res_data, 100 + j);
            tick();
        end
        check("rst_drain_data5", res_data, 105);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        res_ready = 1'b0;
        check("rst_drain_valid", res_valid, 0);
        check("rst_drain_busy", busy, 0);
        check("rst_drain_conv_in", conv_in, 0);
        begin
            bit saw = 1'b0;
            for (int c = 0; c < 12; c++) begin
                if (res_valid) saw = 1'b1;
                tick();
            end
            check("no_results_after_rst", saw, 0);
        end

`ifdef CONV_SEQ_OVERLAP_EN
        // Two back-to-back frames, consumer always ready: period 27 cycles.
        begin
            int hs = 0, cyc = 0, t25 = 0, t50 = 0;
            bit rdy_in_drain = 1'b0;
            res_ready = 1'b1;
            while (hs < 50 && cyc < 300) begin
                pix_valid = 1'b1;
                pix_data  = (hs < 25) ? img1[4*hs +: 4] : img2[4*(hs-25) +: 4];
                if (pix_ready && res_valid) rdy_in_drain = 1'b1;
                if (pix_ready) begin
                    hs++;
                    if (hs == 25) t25 = cyc;
                    if (hs == 50) t50 = cyc;
                end
                tick();
                cyc++;
            end
            pix_valid = 1'b0;
            check("overlap_period", t50 - t25, 27);
            check("overlap_ready_in_drain", rdy_in_drain, 1);
            check("overlap_conv_in", conv_in, img2);
            wait_res();
            drain(-1, 0, 1'b0);
        end

        // Next frame fully loaded during a stalled drain: WAIT follows directly.
        send_frame(img1, 1'b0);
        wait_res();
        send_frame(img3, 1'b0);
        drain(-1, 0, 1'b1);
        check("overlap_wait_direct", pix_ready, 0);
        check("overlap_conv_in3", conv_in, img3);
        wait_res();
        drain(-1, 0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
